fsm_seq_monitor: RTL and testbench

Cycle-by-cycle checker that sits directly downstream of the four-state Moore controller and consumes its 3-bit output code `y` (1→2→{3→}4→1). It follows the legal code sequence and counts completed loops and shortcut loops (2→4, taken when `control`=1). On an illegal code or transition it raises a sticky error that captures the offending codes. Used on-board and in simulation to confirm the controller is live and sequencing correctly.

---
 rtl/fsm_seq_monitor.sv | 151 +++++++++++++++
 tb/tb_fsm_seq_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor
//   Follows the 3-bit output code of the four-state Moore controller
//   (1 -> 2 -> {3 ->} 4 -> 1). It counts completed loops and 2->4
//   shortcuts. It latches a sticky error, together with the offending
//   codes, on any illegal code or transition.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset
//   en         sample enable; 0 holds all state and ignores y_in
//   clear      synchronous clear of error, counters and sync state
//   y_in       controller output code (legal 1..4)
//   in_sync    1 while locked to the sequence
//   err        sticky illegal-sequence flag
//   err_prev   last legal code before the error
//   err_code   offending y_in value
//   loop_cnt   saturating count of 4->1 transitions
//   short_cnt  saturating count of 2->4 transitions
module fsm_seq_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [2:0]       y_in,
  output logic             in_sync,
  output logic             err,
  output logic [2:0]       err_prev,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] loop_cnt,
  output logic [CNT_W-1:0] short_cnt
);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [2:0]       prev_q,     prev_d;
  logic             err_q,      err_d;
  logic [2:0]       err_prev_q, err_prev_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] loop_q,     loop_d;
  logic [CNT_W-1:0] short_q,    short_d;

  logic legal;
  logic is_loop;
  logic is_short;

  // Transition legality against the last accepted code. 1->1 is legal
  // because the upstream controller sits at 1 while it is held in reset.
  always_comb begin
    legal    = 1'b0;
    is_loop  = 1'b0;
    is_short = 1'b0;
    case (prev_q)
      3'd1: legal = (y_in == 3'd1) || (y_in == 3'd2);
      3'd2: begin
        legal    = (y_in == 3'd3) || (y_in == 3'd4);
        is_short = (y_in == 3'd4);
      end
      3'd3: legal = (y_in == 3'd4);
      3'd4: begin
        legal   = (y_in == 3'd1);
        is_loop = (y_in == 3'd1);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    err_d      = err_q;
    err_prev_d = err_prev_q;
    err_code_d = err_code_q;
    loop_d     = loop_q;
    short_d    = short_q;

    if (clear) begin
      state_d    = ST_UNSYNC;
      prev_d     = '0;
      err_d      = 1'b0;
      err_prev_d = '0;
      err_code_d = '0;
      loop_d     = '0;
      short_d    = '0;
    end else if (en) begin
      case (state_q)
        ST_UNSYNC: begin
          if (y_in == 3'd1) begin
            state_d = ST_SYNC;
            prev_d  = 3'd1;
          end
        end
        ST_SYNC: begin
          if (legal) begin
            prev_d = y_in;
            if (is_loop && (loop_q != '1)) begin
              loop_d = loop_q + 1'b1;
            end
            if (is_short && (short_q != '1)) begin
              short_d = short_q + 1'b1;
            end
          end else begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = y_in;
            err_prev_d = prev_q;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_UNSYNC;
          prev_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_UNSYNC;
      prev_q     <= '0;
      err_q      <= 1'b0;
      err_prev_q <= '0;
      err_code_q <= '0;
      loop_q     <= '0;
      short_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      err_prev_q <= err_prev_d;
      err_code_q <= err_code_d;
      loop_q     <= loop_d;
      short_q    <= short_d;
    end
  end

  assign in_sync   = (state_q == ST_SYNC);
  assign err       = err_q;
  assign err_prev  = err_prev_q;
  assign err_code  = err_code_q;
  assign loop_cnt  = loop_q;
  assign short_cnt = short_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed testbench for fsm_seq_monitor. The main instance uses CNT_W=8.
// A second instance uses CNT_W=2 to exercise counter saturation.
module tb_fsm_seq_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clear;
  logic [2:0] y_in;
  logic [2:0] y_in2;

  logic       in_sync,  in_sync2;
  logic       err,      err2;
  logic [2:0] err_prev, err_prev2;
  logic [2:0] err_code, err_code2;
  logic [7:0] loop_cnt, short_cnt;
  logic [1:0] loop_cnt2, short_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  fsm_seq_monitor #(.CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clear     (clear),
    .y_in      (y_in),
    .in_sync   (in_sync),
    .err       (err),
    .err_prev  (err_prev),
    .err_code  (err_code),
    .loop_cnt  (loop_cnt),
    .short_cnt (short_cnt)
  );

  fsm_seq_monitor #(.CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clear     (clear),
    .y_in      (y_in2),
    .in_sync   (in_sync2),
    .err       (err2),
    .err_prev  (err_prev2),
    .err_code  (err_code2),
    .loop_cnt  (loop_cnt2),
    .short_cnt (short_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample, clock it, then settle just past the edge.
  task automatic step(input logic [2:0] v);
    y_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(3'd0);
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_sync"},   32'(in_sync),   0);
    check({tag, ".err"},       32'(err),       0);
    check({tag, ".err_prev"},  32'(err_prev),  0);
    check({tag, ".err_code"},  32'(err_code),  0);
    check({tag, ".loop_cnt"},  32'(loop_cnt),  0);
    check({tag, ".short_cnt"}, 32'(short_cnt), 0);
  endtask

  initial begin
    logic [2:0] seq1 [7];
    seq1 = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

    reset = 1'b0;
    en    = 1'b1;
    clear = 1'b0;
    y_in  = 3'd0;
    y_in2 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Acquisition: 3,4 ignored, first 1 locks, then one full loop.
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      step(seq1[i]);
      if (i < 2) check("acq.unsync", 32'(in_sync), 0);
      if (i == 2) check("acq.first1", 32'(in_sync), 1);
    end
    check("acq.loop",  32'(loop_cnt),  1);
    check("acq.short", 32'(short_cnt), 0);
    check("acq.err",   32'(err),       0);

    // Five shortcut loops: the leading 1 is a 1->1 hold, so only four 4->1 closes.
    for (int r = 0; r < 5; r++) begin
      step(3'd1);
      step(3'd2);
      step(3'd4);
    end
    check("short.loop",  32'(loop_cnt),  5);
    check("short.short", 32'(short_cnt), 5);
    check("short.err",   32'(err),       0);
    step(3'd1);
    check("short.close", 32'(loop_cnt), 6);

    // Illegal 2->1.
    step(3'd2);
    step(3'd1);
    check("ill.err",      32'(err),       1);
    check("ill.err_prev", 32'(err_prev),  2);
    check("ill.err_code", 32'(err_code),  1);
    check("ill.in_sync",  32'(in_sync),   0);
    check("ill.loop",     32'(loop_cnt),  6);
    check("ill.short",    32'(short_cnt), 5);
    step(3'd1); step(3'd2); step(3'd3); step(3'd4); step(3'd1);
    check("ill.hold.loop",  32'(loop_cnt),  6);
    check("ill.hold.short", 32'(short_cnt), 5);
    check("ill.hold.err",   32'(err),       1);
    check("ill.hold.code",  32'(err_code),  1);

    // Clear, resync, inject 6, then clear alongside a second illegal code.
    do_clear();
    check_all_zero("clr1");
    step(3'd1);
    check("inj.sync", 32'(in_sync), 1);
    step(3'd6);
    check("inj.err",      32'(err),      1);
    check("inj.err_code", 32'(err_code), 6);
    check("inj.err_prev", 32'(err_prev), 1);
    clear = 1'b1;
    step(3'd5);
    clear = 1'b0;
    check_all_zero("clr2");
    step(3'd2);
    check("resync.ignore2", 32'(in_sync), 0);
    check("resync.noerr",   32'(err),     0);
    step(3'd1);
    check("resync.sync", 32'(in_sync), 1);

    // Enable stall while y_in wanders to 7, then resume the 3->4 check.
    step(3'd2);
    step(3'd3);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(3'd7);
      check("stall.err",  32'(err),     0);
      check("stall.sync", 32'(in_sync), 1);
    end
    en = 1'b1;
    step(3'd4);
    check("resume.err", 32'(err), 0);
    step(3'd1);
    check("resume.loop", 32'(loop_cnt), 1);
    check("resume.err2", 32'(err),      0);

    // Saturation on the CNT_W=2 instance: five full loops.
    do_clear();
    y_in2 = 3'd1;
    @(posedge clk);
    #1;
    for (int l = 1; l <= 5; l++) begin
      y_in2 = 3'd2; @(posedge clk); #1;
      y_in2 = 3'd3; @(posedge clk); #1;
      y_in2 = 3'd4; @(posedge clk); #1;
      y_in2 = 3'd1; @(posedge clk); #1;
      check("sat.loop", 32'(loop_cnt2), (l > 3) ? 3 : l);
    end
    check("sat.err", 32'(err2), 0);
    y_in2 = 3'd0;

    // Async reset between edges while in ERROR with nonzero counters.
    step(3'd1); step(3'd2); step(3'd3); step(3'd4); step(3'd1);
    step(3'd2); step(3'd2);
    check("pre_rst.err",  32'(err),      1);
    check("pre_rst.loop", 32'(loop_cnt), 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst.sat", 32'(loop_cnt2), 0);
    #2;
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
